shift_sequencer: RTL



---
 rtl/shift_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 32-bit shifter, one power-of-two stage per clock
// Optional rotate-right for op=11 is enabled by defining SHIFT_SEQ_ROR_EN.
module shift_sequencer #(
  parameter int MAX_STEP = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] work, shifted, data_out_q;
  logic [4:0]  remaining, step, rem_nxt;
  logic [1:0]  op_q;
  logic        skip;

  // Largest power of two not exceeding min(remaining, MAX_STEP).
  always_comb begin
    step = 5'd0;
    if (MAX_STEP >= 16 && remaining >= 5'd16)     step = 5'd16;
    else if (MAX_STEP >= 8 && remaining >= 5'd8)  step = 5'd8;
    else if (MAX_STEP >= 4 && remaining >= 5'd4)  step = 5'd4;
    else if (MAX_STEP >= 2 && remaining >= 5'd2)  step = 5'd2;
    else if (remaining >= 5'd1)                   step = 5'd1;
  end

  assign rem_nxt = remaining - step;

  always_comb begin
    shifted = work;
    case (op_q)
      2'b00: shifted = work << step;
      2'b01: shifted = work >> step;
      2'b10: shifted = 32'($signed(work) >>> step);
      default: begin
`ifdef SHIFT_SEQ_ROR_EN
        shifted = (work >> step) | (work << (6'd32 - {1'b0, step}));
`else
        shifted = work;
`endif
      end
    endcase
  end

`ifdef SHIFT_SEQ_ROR_EN
  assign skip = (shamt == 5'd0);
`else
  // Without rotate support op=11 passes the operand through untouched.
  assign skip = (shamt == 5'd0) || (op == 2'b11);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = skip ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem_nxt == 5'd0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work       <= 32'd0;
      remaining  <= 5'd0;
      op_q       <= 2'b00;
      data_out_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= data_in;
            remaining <= shamt;
            op_q      <= op;
            if (skip) data_out_q <= data_in;
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= rem_nxt;
          if (rem_nxt == 5'd0) data_out_q <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_out_q;

endmodule
